// File: rtl/sobel_pkg.sv
// Shared types and helpers for the Sobel window generator and its line buffers.
package sobel_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  // Counter/address width for a range of n values; never narrower than 1 bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One line of pixel storage: synchronous RAM, read-before-write, BRAM-inferable.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 160,
  parameter int AW     = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Raster stream -> registered 3x3 windows with centre coordinates, 2-cycle latency.
// Optional centre tap output p4 when SOBEL_WIN_CENTER_EN is defined.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMG_W  = 160,
  parameter int IMG_H  = 120
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    in_sof,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    out_valid,
  output logic                    out_eof,
  output logic [DATA_W-1:0]       p0,
  output logic [DATA_W-1:0]       p1,
  output logic [DATA_W-1:0]       p2,
  output logic [DATA_W-1:0]       p3,
`ifdef SOBEL_WIN_CENTER_EN
  output logic [DATA_W-1:0]       p4,
`endif
  output logic [DATA_W-1:0]       p5,
  output logic [DATA_W-1:0]       p6,
  output logic [DATA_W-1:0]       p7,
  output logic [DATA_W-1:0]       p8,
  output logic [cnt_w(IMG_W)-1:0] out_x,
  output logic [cnt_w(IMG_H)-1:0] out_y
);

  localparam int XW     = cnt_w(IMG_W);
  localparam int YW     = cnt_w(IMG_H);
  localparam int STAGES = 1;

  state_t        state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          rsel;

  logic          sof_evt, acc, restart, eol, last, win;
  logic [XW-1:0] px;
  logic [YW-1:0] py;
  logic          prsel;

  // A sof pixel is always (0,0) with rsel 0, whatever the counters say.
  assign sof_evt = in_valid & in_sof;
  assign acc     = in_valid & (in_sof | (state != IDLE));
  assign restart = sof_evt & (state != IDLE);
  assign px      = sof_evt ? '0 : x;
  assign py      = sof_evt ? '0 : y;
  assign prsel   = sof_evt ? 1'b0 : rsel;
  assign eol     = (px == XW'(IMG_W - 1));
  assign last    = eol & (py == YW'(IMG_H - 1));
  assign win     = (px >= XW'(2)) & (py >= YW'(2));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      rsel  <= 1'b0;
    end else if (acc) begin
      x <= eol ? '0 : px + 1'b1;
      if (eol) begin
        y    <= last ? '0 : py + 1'b1;
        rsel <= ~prsel;
      end else begin
        y    <= py;
        rsel <= prsel;
      end
      if (last)                           state <= IDLE;
      else if (eol && py == YW'(1))       state <= RUN;
      else if (sof_evt)                   state <= FILL;
    end
  end

  // Buffer rsel holds row y-1; the other holds y-2 and takes the incoming pixel.
  logic [1:0][DATA_W-1:0] lb_rd;

  for (genvar i = 0; i < 2; i++) begin : g_lb
    sobel_line_buffer #(
      .DATA_W(DATA_W),
      .DEPTH (IMG_W),
      .AW    (XW)
    ) u_lb (
      .clk  (clk),
      .en   (acc),
      .we   (prsel == (i == 0)),
      .addr (px),
      .wdata(in_data),
      .rdata(lb_rd[i])
    );
  end

  // Stage 1: input register alongside the buffer read.
  logic [STAGES:0]    vld_pipe;
  logic               s1_acc, s1_rsel, s1_eof;
  logic [DATA_W-1:0]  s1_pix;
  logic [XW-1:0]      s1_cx;
  logic [YW-1:0]      s1_cy;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_acc   <= 1'b0;
    end else begin
      s1_acc      <= acc;
      vld_pipe[0] <= acc & win;
      vld_pipe[1] <= vld_pipe[0] & ~restart;
    end
    if (acc) begin
      s1_pix  <= in_data;
      s1_rsel <= prsel;
      s1_cx   <= px - 1'b1;
      s1_cy   <= py - 1'b1;
      s1_eof  <= last;
    end
  end

  // Stage 2: column shift registers; index 0 is the newest (right) column.
  logic [2:0][DATA_W-1:0] top, mid, bot;
  logic [XW-1:0]          s2_cx;
  logic [YW-1:0]          s2_cy;
  logic                   s2_eof;

  always_ff @(posedge clk) begin
    if (s1_acc) begin
      top    <= {top[1:0], (s1_rsel ? lb_rd[0] : lb_rd[1])};
      mid    <= {mid[1:0], (s1_rsel ? lb_rd[1] : lb_rd[0])};
      bot    <= {bot[1:0], s1_pix};
      s2_cx  <= s1_cx;
      s2_cy  <= s1_cy;
      s2_eof <= s1_eof;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_eof   <= 1'b0;
      {p0, p1, p2, p3, p5, p6, p7, p8} <= '0;
`ifdef SOBEL_WIN_CENTER_EN
      p4 <= '0;
`endif
      out_x <= '0;
      out_y <= '0;
    end else begin
      out_valid <= vld_pipe[STAGES];
      if (vld_pipe[STAGES]) begin
        out_eof <= s2_eof;
        p0 <= top[2]; p1 <= top[1]; p2 <= top[0];
        p3 <= mid[2];               p5 <= mid[0];
        p6 <= bot[2]; p7 <= bot[1]; p8 <= bot[0];
`ifdef SOBEL_WIN_CENTER_EN
        p4 <= mid[1];
`endif
        out_x <= s2_cx;
        out_y <= s2_cy;
      end
    end
  end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on an 8x6 frame, pixel = base + y*16 + x.
module tb_sobel_window_gen;

  localparam int W = 8;
  localparam int H = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_valid, out_eof;
  logic [7:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;
  logic [2:0] out_x, out_y;

`ifndef SOBEL_WIN_CENTER_EN
  assign p4 = 8'h00;
`endif

  sobel_window_gen #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .out_valid(out_valid), .out_eof(out_eof),
    .p0(p0), .p1(p1), .p2(p2), .p3(p3),
`ifdef SOBEL_WIN_CENTER_EN
    .p4(p4),
`endif
    .p5(p5), .p6(p6), .p7(p7), .p8(p8),
    .out_x(out_x), .out_y(out_y)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            eof;
    logic [2:0]      x;
    logic [2:0]      y;
    logic [8:0][7:0] p;
    logic [31:0]     cyc;
  } win_t;

  win_t        got_q[$];
  win_t        exp_q[$];
  win_t        mon_w;
  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid) begin
      mon_w.eof = out_eof; mon_w.x = out_x; mon_w.y = out_y; mon_w.cyc = cyc;
      mon_w.p[0] = p0; mon_w.p[1] = p1; mon_w.p[2] = p2;
      mon_w.p[3] = p3; mon_w.p[4] = p4; mon_w.p[5] = p5;
      mon_w.p[6] = p6; mon_w.p[7] = p7; mon_w.p[8] = p8;
      got_q.push_back(mon_w);
    end
  end

  // Reference window centred at (cx,cy), expected on bench cycle c.
  function automatic win_t mk_win(input int base, input int cx, input int cy,
                                  input bit eof, input int unsigned c);
    win_t w;
    w.eof = eof; w.x = cx[2:0]; w.y = cy[2:0]; w.cyc = c;
    for (int k = 0; k < 9; k++) w.p[k] = 8'(base + (cy - 1 + k / 3) * 16 + (cx - 1 + k % 3));
`ifndef SOBEL_WIN_CENTER_EN
    w.p[4] = 8'h00;
`endif
    return w;
  endfunction

  // Pixel is accepted on the next edge; its window rises two edges after that.
  task automatic drive_pix(input int base, input int x, input int y, input bit sof);
    @(posedge clk); #1;
    in_valid = 1'b1; in_sof = sof; in_data = 8'(base + y * 16 + x);
    if (x >= 2 && y >= 2) exp_q.push_back(mk_win(base, x - 1, y - 1, (x == W - 1 && y == H - 1), cyc + 3));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0; in_sof = 1'b0;
    end
  endtask

  task automatic drive_frame(input int base, input bit gaps);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        if (gaps && $urandom_range(0, 1) == 1) idle(1);
        drive_pix(base, x, y, (x == 0 && y == 0));
      end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_eof !== 1'b0) begin failures++; $display("FAIL reset_eof got=%b exp=0", out_eof); end
    checks++;
    if ({p0, p1, p2, p3, p4, p5, p6, p7, p8} !== 72'h0) begin
      failures++; $display("FAIL reset_taps got=%h exp=0", {p0, p1, p2, p3, p4, p5, p6, p7, p8});
    end
    checks++; if ({out_x, out_y} !== 6'h0) begin failures++; $display("FAIL reset_xy got=%h exp=0", {out_x, out_y}); end
    @(posedge clk); #1 rst = 1'b0;
    idle(2);
  endtask

  task automatic test_stream();
    got_q.delete(); exp_q.delete();
    drive_frame(0, 1'b0);
    idle(5);
    checks++; if (got_q.size() != 24) begin failures++; $display("FAIL stream_count got=%0d exp=24", got_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL stream_win%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    if (got_q.size() > 0) begin
      checks++;
      if ({got_q[0].p[0], got_q[0].p[2], got_q[0].p[3], got_q[0].p[8], got_q[0].x, got_q[0].y} !== {8'h00, 8'h02, 8'h10, 8'h22, 3'd1, 3'd1}) begin
        failures++; $display("FAIL stream_first got=%h exp=%h", got_q[0], {8'h00, 8'h02, 8'h10, 8'h22, 3'd1, 3'd1});
      end
      checks++;
      if ({got_q[$].eof, got_q[$].x, got_q[$].y, got_q[$].p[8]} !== {1'b1, 3'd6, 3'd4, 8'h57}) begin
        failures++; $display("FAIL stream_last got=%h exp=%h", got_q[$], {1'b1, 3'd6, 3'd4, 8'h57});
      end
`ifdef SOBEL_WIN_CENTER_EN
      checks++;
      if ({got_q[0].p[4], got_q[$].p[4]} !== {8'h11, 8'h46}) begin
        failures++; $display("FAIL stream_center got=%h exp=1146", {got_q[0].p[4], got_q[$].p[4]});
      end
`endif
    end
    @(negedge clk);
    checks++; if ({out_valid, p8} !== {1'b0, 8'h57}) begin failures++; $display("FAIL stream_hold got=%h exp=057", {out_valid, p8}); end
  endtask

  task automatic test_gaps();
    got_q.delete(); exp_q.delete();
    drive_frame(0, 1'b1);
    idle(5);
    checks++; if (got_q.size() != 24) begin failures++; $display("FAIL gaps_count got=%0d exp=24", got_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL gaps_win%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_sof_restart();
    got_q.delete(); exp_q.delete();
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < W; x++)
        if (y < 2 || x <= 2) drive_pix(0, x, y, (x == 0 && y == 0));
    void'(exp_q.pop_back());  // (2,2) is still in flight when the new sof lands
    drive_frame(8'h40, 1'b0);
    idle(5);
    checks++; if (got_q.size() != 24) begin failures++; $display("FAIL restart_count got=%0d exp=24", got_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL restart_win%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_midframe();
    got_q.delete(); exp_q.delete();
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < W; x++)
        if (y < 3 || x <= 3) drive_pix(0, x, y, (x == 0 && y == 0));
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({out_valid, out_eof, p0, p4, p8, out_x, out_y} !== 32'h0) begin
      failures++; $display("FAIL rstmid_zero got=%h exp=0", {out_valid, out_eof, p0, p4, p8, out_x, out_y});
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_sof = 1'b0; in_data = 8'($urandom_range(1, 255));
    end
    idle(5);
    checks++; if (got_q.size() != 6) begin failures++; $display("FAIL rstmid_count got=%0d exp=6", got_q.size()); end
    checks++;
    if ({out_valid, p0, p8, out_x, out_y} !== 23'h0) begin
      failures++; $display("FAIL rstmid_nosof got=%h exp=0", {out_valid, p0, p8, out_x, out_y});
    end
    drive_frame(8'h10, 1'b0);
    idle(5);
    checks++; if (got_q.size() != 30) begin failures++; $display("FAIL rstmid_total got=%0d exp=30", got_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rstmid_win%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    got_q.delete(); exp_q.delete();
    drive_frame(0, 1'b0);
    drive_frame(8'h80, 1'b0);
    idle(5);
    checks++; if (got_q.size() != 48) begin failures++; $display("FAIL b2b_count got=%0d exp=48", got_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_win%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_gaps();
    test_sof_restart();
    test_reset_midframe();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

Parametrised 3x3 window generator for the Sobel datapath. It accepts a raster-order pixel stream and stores the two previous rows in rotating line buffers. It emits one registered 3x3 neighbourhood per interior pixel, together with the window's centre coordinates. It sits between the pixel source (camera/RAM reader) and the Sobel gradient/magnitude stage. It replaces fixed-count RAM reordering with an internal rotating row pointer and column shift registers, and adds stall tolerance and frame resynchronisation.

## Interface
- DATA_W, 8, pixel width in bits
- IMG_W, 160, pixels per line; must be >= 4
- IMG_H, 120, lines per frame; must be >= 3
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  pixel accepted on this edge (no back-pressure; always accepted)
- in_sof  in  1  qualifies in_valid: pixel is (0,0) of a new frame
- in_data  in  DATA_W  pixel value
- out_valid  out  1  window outputs valid this cycle
- out_eof  out  1  with out_valid: last window of the frame
- p0,p1,p2  out  DATA_W each  top row, left/centre/right
- p3,p5  out  DATA_W each  middle row, left/right
- p6,p7,p8  out  DATA_W each  bottom row, left/centre/right
- out_x  out  $clog2(IMG_W)  centre column of the window
- out_y  out  $clog2(IMG_H)  centre row of the window

## Operation
- FSM states: IDLE, FILL, RUN.
  - IDLE → FILL on in_valid & in_sof. Pixels arriving without in_sof in IDLE are ignored.
  - FILL → RUN after the last pixel of row 1 is accepted.
  - RUN → IDLE after pixel (IMG_W-1, IMG_H-1) is accepted.
- in_valid & in_sof in FILL or RUN restarts the frame. The pixel is taken as (0,0), the counters and row pointer reset, and in-flight windows from the old frame are dropped (their out_valid is suppressed).
- Column counter x (0..IMG_W-1) and row counter y (0..IMG_H-1) advance only on accepted pixels. x wraps to 0 and y increments at the end of each line.
- Line buffers:
  - There are two buffers of IMG_W words, addressed by x, with read-before-write.
  - Row pointer rsel marks which buffer holds row y-1. The other buffer holds y-2 and is overwritten by the incoming pixel.
  - rsel toggles at every end of line and resets to 0 on rst/sof.
- Three 3-deep column shift registers (top = y-2, mid = y-1, bottom = current) shift only on accepted pixels.
- A window is emitted for pixel (x,y) when x >= 2 and y >= 2. Its centre is (x-1, y-1). Each frame therefore yields (IMG_W-2)*(IMG_H-2) windows. There is no border padding and no windows that straddle lines.
- out_eof is asserted with the window centred at (IMG_W-2, IMG_H-2).
- All outputs are registered. They hold their last values while out_valid is low.
- Reset values: every output 0, state IDLE, x=y=0, rsel=0, pipeline valids 0. Line buffer contents are don't-care.

## Timing
- Latency is exactly 2 cycles, from the edge accepting the bottom-right pixel to the edge at which out_valid rises.
  - Stage 1: buffer read and input register.
  - Stage 2: shift registers, then output register.
- Throughput is one window per accepted pixel. Gaps in in_valid propagate as gaps in out_valid, and window order is preserved.
- rst mid-frame takes effect on the same edge. Outputs are 0 in the following cycle, and windows in flight are discarded.
- in_sof coinciding with the final pixel of the previous frame: the new frame wins, and the previous frame's last window is not emitted.

## Configuration
- SOBEL_WIN_CENTER_EN:
  - Defined: adds output port p4 (DATA_W), the window centre, registered and timed like the other taps, reset 0.
  - Undefined: port p4 is absent and the centre tap is not stored beyond the shift registers.

## Structure
- Shared package sobel_pkg holds:
  - the default DATA_W;
  - the FSM state typedef (IDLE/FILL/RUN);
  - width helper functions for the coordinate counters.
- Sub-module sobel_line_buffer: one IMG_W x DATA_W synchronous RAM with read-before-write, inferable as iCE40 BRAM. It is instantiated twice.

## Test plan
- Continuous stream, IMG_W=8, IMG_H=6, pixel = y*16+x:
  - Produces 24 windows.
  - First window 2 cycles after pixel (2,2): p0..p2=00,01,02; p3=10; p5=12; p6..p8=20,21,22; out_x=1, out_y=1.
  - Last window has out_eof=1 at (6,4), with p8=0x57.
- Same frame with random 50% in_valid gaps → identical window sequence; out_valid low during the matching gaps.
- in_sof reasserted at old pixel (3,2) → no further old-frame windows; the next window is the new frame's (1,1), 2 cycles after its pixel (2,2).
- rst asserted mid row 3, then pixels without in_sof → all outputs 0 and no out_valid. A subsequent sof frame gives the correct 24 windows.
- Back-to-back frames, with sof the cycle after pixel (7,5) → second frame windows are correct, with no stale rows from frame 1.
- With SOBEL_WIN_CENTER_EN defined, test 1 → p4=0x11 on the first window and p4=0x46 on the last.
